// File: rtl/demux_sched_8.sv
// demux_sched_8
// Sequencer for a 1-to-8 demultiplexer. It takes words from a single
// producer and steers each word to exactly one of eight consumer channels.
// The channel is chosen either round-robin over an enable mask or from a
// fixed select. One word is held in a registered output stage until the
// chosen channel takes it.
//
// Handshake rule, used on every port pair: a word moves across an interface
// on a rising clock edge where its valid and ready are both high. Valid
// never depends on ready in the same cycle. Ready may depend on valid.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_data   word to distribute (WIDTH bits)
//   in_valid  producer has a word
//   in_ready  block accepts in_data this cycle
//   mode      0 = round-robin over en_mask, 1 = fixed channel fix_sel
//   en_mask   round-robin channel enables, bit i = channel i
//   fix_sel   channel used in fixed mode
//   out_data  held word, shared by all channels
//   out_valid one-hot valid per channel, all zero when empty
//   out_ready per-channel consumer ready
//   cur_sel   channel of the held word, or the last served channel when empty
//   busy      output stage holds a word (FSM state: 0 = EMPTY, 1 = FULL)
module demux_sched_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [7:0]       en_mask,
    input  logic [2:0]       fix_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [2:0]       cur_sel,
    output logic             busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    // The channel of the held word and the round-robin pointer always
    // change together and only on acceptance, so one register serves as
    // both.
    logic [2:0]       sel_q;

    logic [2:0]       rr_pick;
    logic             rr_found;
    logic [2:0]       idx;
    logic [2:0]       pick;
    logic             pick_ok;
    logic             fire;
    logic             accept;

    // Round-robin search: start just after the pointer and wrap modulo 8.
    // The pointer itself is visited last (k = 8 wraps back to sel_q).
    always_comb begin
        rr_pick  = sel_q;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = sel_q + 3'(k);
            if (!rr_found && en_mask[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    assign pick     = mode ? fix_sel : rr_pick;
    assign pick_ok  = mode | rr_found;

    assign busy     = (state_q == FULL);
    // Only the ready bit of the held channel matters.
    assign fire     = busy & out_ready[sel_q];
    // A word may be taken in the same cycle the held one leaves.
    assign in_ready = pick_ok & (~busy | fire);
    assign accept   = in_valid & in_ready;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (fire && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output stage. Configuration is sampled only here, at acceptance, so
    // later changes to mode, en_mask or fix_sel never move a held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= 3'd7;
        end else if (accept) begin
            data_q <= in_data;
            sel_q  <= pick;
        end
    end

    assign out_data  = data_q;
    assign cur_sel   = sel_q;
    assign out_valid = busy ? (8'b1 << sel_q) : 8'b0;

endmodule

// File: tb/tb_demux_sched_8.sv
// tb_demux_sched_8
// Self-checking bench for demux_sched_8. Each scenario task drives the
// stimulus and checks its own signals. Every word it sends pushes
// {channel, data} onto exp_q. A negedge monitor pops one entry for each
// channel handshake it observes and compares it with the outputs.
module tb_demux_sched_8;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [7:0]       en_mask;
    logic [2:0]       fix_sel;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [2:0]       cur_sel;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // {channel[2:0], data[7:0]}
    logic [WIDTH+2:0] exp_q[$];

    demux_sched_8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .en_mask   (en_mask),
        .fix_sel   (fix_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [WIDTH+2:0] e;
        logic [7:0]       exp_ov;
        if (!rst) begin
            checks++;
            if ($isunknown(out_valid) || $countones(out_valid) > 1) begin
                errors++;
                $display("FAIL onehot: out_valid=%b required one-hot or zero", out_valid);
            end
            if ((out_valid & out_ready) != 8'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fire: out_valid=%h out_data=%h required no transfer",
                             out_valid, out_data);
                end else begin
                    e = exp_q.pop_front();
                    exp_ov = 8'b1 << e[WIDTH+2:WIDTH];
                    if (out_valid !== exp_ov || out_data !== e[WIDTH-1:0]) begin
                        errors++;
                        $display("FAIL delivery: out_valid=%h out_data=%h required out_valid=%h out_data=%h",
                                 out_valid, out_data, exp_ov, e[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        en_mask   = 8'hFF;
        fix_sel   = 3'd0;
        out_ready = 8'hFF;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Presents a word and returns on the cycle after it is accepted.
    // in_valid is left high so the caller can stream words back to back.
    task automatic drive_word(input logic [WIDTH-1:0] d, input logic [2:0] ch, output int waits);
        waits    = 0;
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back({ch, d});
        @(negedge clk);
        while (in_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 50 cycles (data %h)", in_ready, d);
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; mode = 1'b0; en_mask = 8'hFF;
        fix_sel = 3'd0; out_ready = 8'hFF;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 8'h00 || out_data !== 8'h00 || cur_sel !== 3'd7) begin
            errors++;
            $display("FAIL reset_state: busy=%b out_valid=%h out_data=%h cur_sel=%0d required 0/00/00/7",
                     busy, out_valid, out_data, cur_sel);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 8'h00 || cur_sel !== 3'd7 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: busy=%b out_valid=%h cur_sel=%0d in_ready=%b required 0/00/7/1",
                     busy, out_valid, cur_sel, in_ready);
        end
    endtask

    task automatic test_rr_stream();
        int w;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_word(8'hA0 + 8'(i), 3'(i % 8), w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL rr_bubble: word %0d waited %0d cycles required 0", i, w);
            end
            // Now just past the accepting edge: the word is held.
            #1;
            checks++;
            if (out_valid !== (8'b1 << (i % 8)) || cur_sel !== 3'(i % 8)) begin
                errors++;
                $display("FAIL rr_seq: word %0d out_valid=%h cur_sel=%0d required %h/%0d",
                         i, out_valid, cur_sel, 8'b1 << (i % 8), i % 8);
            end
        end
        drain("rr_stream");
    endtask

    task automatic test_rr_mask();
        int w;
        logic [2:0] chs[5];
        chs = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        do_reset();
        en_mask = 8'b1000_0101;
        for (int i = 0; i < 5; i++) begin
            drive_word(8'hB0 + 8'(i), chs[i], w);
            #1;
            checks++;
            if (cur_sel !== chs[i] || w != 0) begin
                errors++;
                $display("FAIL rr_mask: word %0d cur_sel=%0d waits=%0d required %0d/0", i, cur_sel, w, chs[i]);
            end
        end
        drain("rr_mask");
    endtask

    task automatic test_fixed_stall();
        int w;
        do_reset();
        mode      = 1'b1;
        fix_sel   = 3'd5;
        out_ready = 8'hDF;
        drive_word(8'hC0, 3'd5, w);
        in_data = 8'hC1;
        exp_q.push_back({3'd5, 8'hC1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 8'h20 || out_data !== 8'hC0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL fixed_hold: cycle %0d out_valid=%h out_data=%h in_ready=%b required 20/c0/0",
                         i, out_valid, out_data, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 8'hFF;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fixed_fire_accept: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 8'h20 || out_data !== 8'hC1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fixed_no_bubble: out_valid=%h out_data=%h busy=%b required 20/c1/1",
                     out_valid, out_data, busy);
        end
        drain("fixed_stall");
    endtask

    task automatic test_empty_mask();
        int w;
        do_reset();
        en_mask  = 8'h00;
        in_data  = 8'hD0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 8'h00) begin
                errors++;
                $display("FAIL empty_mask: in_ready=%b busy=%b out_valid=%h required 0/0/00",
                         in_ready, busy, out_valid);
            end
        end
        @(posedge clk); #1;
        en_mask = 8'h10;
        drive_word(8'hD0, 3'd4, w);
        drain("empty_mask");
        checks++;
        if (cur_sel !== 3'd4 || out_data !== 8'hD0) begin
            errors++;
            $display("FAIL empty_hold_last: cur_sel=%0d out_data=%h required 4/d0", cur_sel, out_data);
        end
    endtask

    task automatic test_config_change();
        int w;
        do_reset();
        en_mask   = 8'h08;
        out_ready = 8'h00;
        drive_word(8'hE0, 3'd3, w);
        in_valid = 1'b0;
        en_mask  = 8'h01;
        mode     = 1'b1;
        fix_sel  = 3'd6;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 8'h08 || cur_sel !== 3'd3 || out_data !== 8'hE0) begin
                errors++;
                $display("FAIL cfg_hold: out_valid=%h cur_sel=%0d out_data=%h required 08/3/e0",
                         out_valid, cur_sel, out_data);
            end
        end
        @(posedge clk); #1;
        out_ready = 8'hFF;
        drive_word(8'hE1, 3'd6, w);
        drain("config_change");
    endtask

    task automatic test_reset_mid_hold();
        int w;
        do_reset();
        en_mask   = 8'h08;
        out_ready = 8'h00;
        drive_word(8'hF0, 3'd3, w);
        in_valid = 1'b0;
        // The held word is discarded by reset, so it is never delivered.
        void'(exp_q.pop_back());
        @(negedge clk);
        checks++;
        if (out_valid !== 8'h08) begin
            errors++;
            $display("FAIL pre_reset_hold: out_valid=%h required 08", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 8'h00 || busy !== 1'b0 || cur_sel !== 3'd7) begin
            errors++;
            $display("FAIL async_reset: out_valid=%h busy=%b cur_sel=%0d required 00/0/7",
                     out_valid, busy, cur_sel);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        mode      = 1'b0;
        en_mask   = 8'hFF;
        out_ready = 8'hFF;
        drive_word(8'hF1, 3'd0, w);
        #1;
        checks++;
        if (cur_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_first_pick: cur_sel=%0d required 0", cur_sel);
        end
        drain("reset_mid_hold");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_rr_stream();
        test_rr_mask();
        test_fixed_stall();
        test_empty_mask();
        test_config_change();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
